// File: rtl/seq_step_player.sv
// Pattern-ROM sequence player: button-selected sequence, one ROM word per slow_tick,
// one-cycle valid strobe per word, loop/one-shot playback with in-word end markers.
module seq_step_player #(
  parameter int unsigned SEQ_W    = 6,
  parameter int unsigned STEP_W   = 4,
  parameter int unsigned DATA_W   = 32,
  parameter bit          WRAP_SEQ = 1'b1
) (
  input  logic                    CLK_50,
  input  logic                    reset,
  input  logic                    pb_seq_up,
  input  logic                    pb_seq_dn,
  input  logic                    slow_tick,
  input  logic                    loop_mode,
  input  logic [DATA_W-1:0]       rom_q,
  output logic [SEQ_W+STEP_W-1:0] rom_addr,
  output logic [SEQ_W-1:0]        seq_num,
  output logic [STEP_W-1:0]       step,
  output logic [DATA_W-2:0]       data_out,
  output logic                    data_valid,
  output logic                    busy,
  output logic                    seq_done
);

  typedef enum logic [2:0] {StIdle, StFetch, StLatch, StHold, StDone} state_e;

  localparam logic [SEQ_W-1:0]  SeqMax  = '1;
  localparam logic [STEP_W-1:0] StepMax = '1;

  state_e              state_q, state_d;
  logic [SEQ_W-1:0]    seq_num_q, seq_num_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [DATA_W-2:0]   data_out_q, data_out_d;
  logic                data_valid_q, data_valid_d;
  logic                last_q, last_d;
  logic                pb_up_prev_q, pb_dn_prev_q;

  logic                up_edge, dn_edge, seq_change;

  always_comb begin
    up_edge   = pb_seq_up & ~pb_up_prev_q;
    dn_edge   = pb_seq_dn & ~pb_dn_prev_q;
    seq_num_d = seq_num_q;
    // Simultaneous edges cancel; a saturated counter blocks the edge entirely.
    if (up_edge && !dn_edge) begin
      if (WRAP_SEQ || (seq_num_q != SeqMax)) seq_num_d = seq_num_q + 1'b1;
    end else if (dn_edge && !up_edge) begin
      if (WRAP_SEQ || (seq_num_q != '0)) seq_num_d = seq_num_q - 1'b1;
    end
    seq_change = (seq_num_d != seq_num_q);
  end

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    last_d       = last_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    if (seq_change) begin
      // A new selection restarts from any state and swallows a coincident tick.
      step_d  = '0;
      last_d  = 1'b0;
      state_d = StFetch;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StFetch;
        StFetch: state_d = StLatch;
        StLatch: begin
          data_out_d   = rom_q[DATA_W-2:0];
          data_valid_d = 1'b1;
          last_d       = rom_q[DATA_W-1] | (step_q == StepMax);
          state_d      = StHold;
        end
        StHold: begin
          if (slow_tick) begin
            if (!last_q) begin
              step_d  = step_q + 1'b1;
              state_d = StFetch;
            end else if (loop_mode) begin
              step_d  = '0;
              last_d  = 1'b0;
              state_d = StFetch;
            end else begin
              state_d = StDone;
            end
          end
        end
        StDone:  state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK_50 or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      seq_num_q    <= '0;
      step_q       <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      last_q       <= 1'b0;
      pb_up_prev_q <= 1'b0;
      pb_dn_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      seq_num_q    <= seq_num_d;
      step_q       <= step_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      last_q       <= last_d;
      pb_up_prev_q <= pb_seq_up;
      pb_dn_prev_q <= pb_seq_dn;
    end
  end

  assign rom_addr   = {seq_num_q, step_q};
  assign seq_num    = seq_num_q;
  assign step       = step_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign busy       = (state_q == StFetch) || (state_q == StLatch) || (state_q == StHold);
  assign seq_done   = (state_q == StDone);

endmodule

// File: tb/tb_seq_step_player.sv
// Bench for seq_step_player: a wrapping and a saturating instance share stimulus and are
// compared every cycle against a countdown-based playback model, plus directed scenarios.
module tb_seq_step_player;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pb_up = 1'b0, pb_dn = 1'b0, tick = 1'b0, loop = 1'b0;
  logic [31:0] rom_q_w, rom_q_s;
  logic [9:0]  addr_w, addr_s;
  logic [5:0]  seq_w, seq_s;
  logic [3:0]  step_w, step_s;
  logic [30:0] dout_w, dout_s;
  logic        dv_w, dv_s, busy_w, busy_s, done_w, done_s;

  logic [31:0] mem [1024];

  int n_checks = 0;
  int n_err = 0;

  seq_step_player #(.SEQ_W(6), .STEP_W(4), .DATA_W(32), .WRAP_SEQ(1'b1)) dut (
    .CLK_50(clk), .reset(rst_n), .pb_seq_up(pb_up), .pb_seq_dn(pb_dn), .slow_tick(tick),
    .loop_mode(loop), .rom_q(rom_q_w), .rom_addr(addr_w), .seq_num(seq_w), .step(step_w),
    .data_out(dout_w), .data_valid(dv_w), .busy(busy_w), .seq_done(done_w)
  );

  seq_step_player #(.SEQ_W(6), .STEP_W(4), .DATA_W(32), .WRAP_SEQ(1'b0)) dut_sat (
    .CLK_50(clk), .reset(rst_n), .pb_seq_up(pb_up), .pb_seq_dn(pb_dn), .slow_tick(tick),
    .loop_mode(loop), .rom_q(rom_q_s), .rom_addr(addr_s), .seq_num(seq_s), .step(step_s),
    .data_out(dout_s), .data_valid(dv_s), .busy(busy_s), .seq_done(done_s)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data one cycle after the address.
  always @(posedge clk) begin
    rom_q_w <= mem[addr_w];
    rom_q_s <= mem[addr_s];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model. m_cnt counts cycles until the word is latched:
  // 3 = just out of reset, 2 = address presented, 1 = latching, 0 = word shown.
  int          m_seq [2];
  int          m_step[2];
  int          m_cnt [2];
  bit          m_last[2];
  bit          m_done[2];
  bit          m_valid[2];
  logic [30:0] m_data[2];
  bit          m_wrap[2];
  bit          prev_up, prev_dn;

  task automatic model_reset(input int i);
    m_seq[i] = 0; m_step[i] = 0; m_cnt[i] = 3; m_last[i] = 0; m_done[i] = 0;
    m_valid[i] = 0; m_data[i] = '0;
  endtask

  task automatic model_step(input int i, input bit up_e, input bit dn_e);
    int          ns;
    logic [31:0] word;
    ns = m_seq[i];
    m_valid[i] = 0;
    if (up_e && !dn_e) ns = m_wrap[i] ? (m_seq[i] + 1) % 64 : (m_seq[i] == 63 ? 63 : m_seq[i] + 1);
    if (dn_e && !up_e) ns = m_wrap[i] ? (m_seq[i] + 63) % 64 : (m_seq[i] == 0 ? 0 : m_seq[i] - 1);
    if (ns != m_seq[i]) begin
      m_seq[i] = ns; m_step[i] = 0; m_last[i] = 0; m_done[i] = 0; m_cnt[i] = 2;
    end else if (m_cnt[i] > 1) begin
      m_cnt[i] = m_cnt[i] - 1;
    end else if (m_cnt[i] == 1) begin
      word = mem[m_seq[i] * 16 + m_step[i]];
      m_data[i]  = word[30:0];
      m_valid[i] = 1;
      m_last[i]  = word[31] || (m_step[i] == 15);
      m_cnt[i]   = 0;
    end else if (!m_done[i] && tick) begin
      if (!m_last[i]) begin
        m_step[i] = m_step[i] + 1; m_cnt[i] = 2;
      end else if (loop) begin
        m_step[i] = 0; m_last[i] = 0; m_cnt[i] = 2;
      end else begin
        m_done[i] = 1;
      end
    end
  endtask

  task automatic cmp_inst(input string p, input int i, input logic [5:0] s, input logic [3:0] st,
                          input logic [9:0] a, input logic [30:0] d, input logic v,
                          input logic b, input logic dn);
    bit exp_busy;
    exp_busy = (m_cnt[i] == 2) || (m_cnt[i] == 1) || (m_cnt[i] == 0 && !m_done[i]);
    check({p, ".seq_num"}, 64'(s), 64'(m_seq[i]));
    check({p, ".step"}, 64'(st), 64'(m_step[i]));
    check({p, ".rom_addr"}, 64'(a), 64'(m_seq[i] * 16 + m_step[i]));
    check({p, ".data_out"}, 64'(d), 64'(m_data[i]));
    check({p, ".data_valid"}, 64'(v), 64'(m_valid[i]));
    check({p, ".busy"}, 64'(b), 64'(exp_busy));
    check({p, ".seq_done"}, 64'(dn), 64'(m_cnt[i] == 0 && m_done[i]));
  endtask

  logic [30:0] cap_w[$];
  bit          done_seen;

  always begin
    bit up_e, dn_e;
    @(posedge clk);
    if (!rst_n) begin
      model_reset(0); model_reset(1);
      prev_up = 0; prev_dn = 0;
    end else begin
      up_e = pb_up && !prev_up;
      dn_e = pb_dn && !prev_dn;
      model_step(0, up_e, dn_e);
      model_step(1, up_e, dn_e);
      prev_up = pb_up; prev_dn = pb_dn;
    end
    #1;
    cmp_inst("wrap", 0, seq_w, step_w, addr_w, dout_w, dv_w, busy_w, done_w);
    cmp_inst("sat", 1, seq_s, step_s, addr_s, dout_s, dv_s, busy_s, done_s);
    if (dv_w) cap_w.push_back(dout_w);
    if (done_w) done_seen = 1;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_once();
    tick = 1'b1; @(negedge clk); tick = 1'b0;
  endtask

  task automatic press(input bit up, input bit dn);
    pb_up = up; pb_dn = dn; @(negedge clk); pb_up = 1'b0; pb_dn = 1'b0;
  endtask

  task automatic check_zero(input string p);
    check({p, ".seq_num"}, 64'(seq_w), 64'd0);
    check({p, ".step"}, 64'(step_w), 64'd0);
    check({p, ".rom_addr"}, 64'(addr_w), 64'd0);
    check({p, ".data_out"}, 64'(dout_w), 64'd0);
    check({p, ".data_valid"}, 64'(dv_w), 64'd0);
    check({p, ".busy"}, 64'(busy_w), 64'd0);
    check({p, ".seq_done"}, 64'(done_w), 64'd0);
  endtask

  logic [30:0] pat [3];

  initial begin
    bit new_up, new_dn;
    m_wrap[0] = 1; m_wrap[1] = 0;
    done_seen = 0;
    pat[0] = 31'hA; pat[1] = 31'hB; pat[2] = 31'hC;
    for (int k = 0; k < 1024; k++) begin
      mem[k] = $urandom;
      mem[k][31] = ($urandom_range(0, 3) == 0);
    end
    mem[0] = 32'h0000_000A; mem[1] = 32'h0000_000B; mem[2] = 32'h8000_000C;
    for (int k = 16; k < 32; k++) mem[k][31] = 1'b0;

    // Reset, one-shot playback of sequence 0.
    #3 rst_n = 1'b0;
    cycles(2);
    check_zero("reset");
    rst_n = 1'b1;
    for (int t = 0; t < 3; t++) begin
      cycles(9); tick_once();
    end
    cycles(10);
    check("oneshot.count", 64'(cap_w.size()), 64'd3);
    for (int k = 0; k < 3 && k < cap_w.size(); k++) check("oneshot.word", 64'(cap_w[k]), 64'(pat[k]));
    check("oneshot.seq_done", 64'(done_w), 64'd1);
    check("oneshot.busy", 64'(busy_w), 64'd0);
    check("oneshot.step", 64'(step_w), 64'd2);

    // Loop mode over the same sequence.
    rst_n = 1'b0; cycles(2);
    cap_w.delete(); done_seen = 0;
    rst_n = 1'b1; loop = 1'b1;
    for (int t = 0; t < 10; t++) begin
      cycles(9); tick_once();
    end
    cycles(5);
    check("loop.count", 64'(cap_w.size()), 64'd11);
    for (int k = 0; k < cap_w.size(); k++) check("loop.word", 64'(cap_w[k]), 64'(pat[k % 3]));
    check("loop.no_done", 64'(done_seen), 64'd0);

    // Up edge in HOLD at step 5 with a coincident tick.
    loop = 1'b0;
    press(1, 0); cycles(4);
    for (int t = 0; t < 5; t++) begin
      tick_once(); cycles(4);
    end
    check("hold5.step", 64'(step_w), 64'd5);
    pb_up = 1'b1; tick = 1'b1; @(negedge clk); pb_up = 1'b0; tick = 1'b0;
    check("hold5.seq", 64'(seq_w), 64'd2);
    check("hold5.step0", 64'(step_w), 64'd0);
    cycles(2);
    check("hold5.valid", 64'(dv_w), 64'd1);
    check("hold5.data", 64'(dout_w), 64'(mem[32][30:0]));

    // Sequence 1 has no end markers: plays to step 15, then stops.
    press(0, 1); cycles(4);
    for (int t = 0; t < 16; t++) begin
      tick_once(); cycles(4);
    end
    check("full.seq_done", 64'(done_w), 64'd1);
    check("full.step", 64'(step_w), 64'd15);

    // Down edge at sequence 0: wraps on one instance, blocked on the other.
    press(0, 1); cycles(4);
    pb_dn = 1'b1; @(negedge clk); pb_dn = 1'b0;
    check("wrap.seq", 64'(seq_w), 64'd63);
    check("wrap.addr", 64'(addr_w), 64'd1008);
    check("sat.seq", 64'(seq_s), 64'd0);
    cycles(2);
    check("wrap.valid", 64'(dv_w), 64'd1);
    check("sat.no_valid", 64'(dv_s), 64'd0);

    // Both edges together leave the selection alone.
    cycles(3);
    press(1, 1); cycles(1);
    check("both.seq", 64'(seq_w), 64'd63);

    // Asynchronous reset in HOLD.
    cycles(4);
    #2 rst_n = 1'b0;
    #1 check_zero("async");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("async.fetch_busy", 64'(busy_w), 64'd1);
    cycles(2);
    check("async.valid", 64'(dv_w), 64'd1);

    // Randomized phase; ticks never share a cycle with a button edge.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0; pb_up = 1'b0; pb_dn = 1'b0; tick = 1'b0;
      end else begin
        new_up = ($urandom_range(0, 24) == 0) ? ~pb_up : pb_up;
        new_dn = ($urandom_range(0, 24) == 0) ? ~pb_dn : pb_dn;
        tick = ((new_up && !pb_up) || (new_dn && !pb_dn)) ? 1'b0 : ($urandom_range(0, 3) == 0);
        pb_up = new_up; pb_dn = new_dn;
        if ($urandom_range(0, 99) == 0) loop = ~loop;
      end
    end
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
